// File: rtl/spike_codec_pkg.sv
// rtl/spike_codec_pkg.sv - shared types and helpers for the spike rate decoder
// Purpose: decoder FSM state type, EWMA shift amount and saturating counter add.
// Ports: none (package).
package spike_codec_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;

  // Shift used by the optional leaky average: new = old - old/4 + res/4.
  localparam int EWMA_SH = 2;

  // Saturating increment. Callers pass their counter zero-extended and the
  // all-ones value of their counter width, then cast the result back down.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic        inc,
                                          input logic [31:0] max_val);
    if (inc && (cnt < max_val))
      return cnt + 32'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/spike_window_counter.sv
// rtl/spike_window_counter.sv - window cycle counter with latched window length
// Purpose: counts cycles of the current window and flags its last cycle.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a new window (latches window_len, cycle count to 0)
//   clear        abandon the window (cycle count to 0)
//   window_len   requested length; 0 is treated as 1
//   win_end      current cycle is the last cycle of the window
import spike_codec_pkg::*;

module spike_window_counter #(
  parameter int WINDOW_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                clear,
  input  logic [WINDOW_W-1:0] window_len,
  output logic                win_end
);

  logic [WINDOW_W-1:0] r_cyc;
  logic [WINDOW_W-1:0] r_len_q;
  logic [WINDOW_W-1:0] w_len_eff;

  assign w_len_eff = (window_len == '0) ? WINDOW_W'(1) : window_len;
  // r_len_q is never 0, so len_q-1 cannot underflow and r_cyc never wraps.
  assign win_end   = (r_cyc == (r_len_q - WINDOW_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc   <= '0;
      r_len_q <= WINDOW_W'(1);
    end else if (start) begin
      r_cyc   <= '0;
      r_len_q <= w_len_eff;
    end else if (clear) begin
      r_cyc   <= '0;
    end else if (win_end) begin
      // Back-to-back windows: reload length with no dead cycle.
      r_cyc   <= '0;
      r_len_q <= w_len_eff;
    end else begin
      r_cyc   <= r_cyc + WINDOW_W'(1);
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - spike-count rate decoder over programmable windows
// Purpose: counts spikes over window_len cycles and presents each count on a
//   valid/ready output. Optional macro SPIKE_DECODER_EWMA_EN replaces the raw
//   count with a leaky 0.75/0.25 running average.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   spike_in     spike sampled every counting cycle
//   enable       1 runs windows back-to-back, 0 returns to idle
//   window_len   window length in cycles (0 treated as 1)
//   rate         result of the last completed window
//   rate_valid   rate holds an unconsumed result
//   rate_ready   consumer accepts rate when rate_valid & rate_ready
//   overrun      one-cycle pulse when an unconsumed result is overwritten
import spike_codec_pkg::*;

module spike_rate_decoder #(
  parameter int WINDOW_W = 10,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spike_in,
  input  logic                enable,
  input  logic [WINDOW_W-1:0] window_len,
  output logic [CNT_W-1:0]    rate,
  output logic                rate_valid,
  input  logic                rate_ready,
  output logic                overrun
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  dec_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rate;
  logic             r_rate_valid;
  logic             r_overrun;

  logic             w_start;
  logic             w_clear;
  logic             w_win_end;
  logic [CNT_W-1:0] w_res;
  logic [CNT_W-1:0] w_rate_next;

  assign w_start = (r_state == IDLE) && enable;
  assign w_clear = !enable;

  spike_window_counter #(.WINDOW_W(WINDOW_W)) u_win (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_start),
    .clear      (w_clear),
    .window_len (window_len),
    .win_end    (w_win_end)
  );

  assign w_res = CNT_W'(sat_inc(32'(r_cnt), spike_in, CNT_MAX));

`ifdef SPIKE_DECODER_EWMA_EN
  // old - old/4 + res/4 <= 3/4*max + 1/4*max, so no overflow in CNT_W bits.
  assign w_rate_next = r_rate - (r_rate >> EWMA_SH) + (w_res >> EWMA_SH);
`else
  assign w_rate_next = w_res;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rate       <= '0;
      r_rate_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      // Acceptance; a window ending on this same edge re-asserts valid below.
      if (r_rate_valid && rate_ready)
        r_rate_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= COUNT;
            r_cnt   <= '0;
          end
        end
        COUNT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_win_end) begin
            r_rate       <= w_rate_next;
            r_rate_valid <= 1'b1;
            r_overrun    <= r_rate_valid && !rate_ready;
            r_cnt        <= '0;
          end else begin
            r_cnt <= w_res;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rate       = r_rate;
  assign rate_valid = r_rate_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb/tb_spike_rate_decoder.sv - scoreboard bench for spike_rate_decoder
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spike_in;
  logic       enable;
  logic [9:0] window_len;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ready;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_seen = 0;
  int ovr_base;

  logic [7:0] exp_q[$];
  logic [7:0] m_rate;

  spike_rate_decoder #(.WINDOW_W(10), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .enable     (enable),
    .window_len (window_len),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Records a completed window's raw count; push=1 when it will be consumed.
  task automatic note_window(input logic [7:0] res, input bit push);
    logic [7:0] e;
`ifdef SPIKE_DECODER_EWMA_EN
    m_rate = m_rate - (m_rate >> 2) + (res >> 2);
    e = m_rate;
`else
    e = res;
`endif
    if (push) exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rate_valid && rate_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        check("rate", int'(rate), int'(exp_q.pop_front()));
      end
    end
    if (rst_n && overrun) ovr_seen++;
  end

  initial begin
    rst_n = 1'b0; spike_in = 1'b0; enable = 1'b0;
    window_len = 10'd10; rate_ready = 1'b1; m_rate = 8'd0;
    tick(3);
    check("reset_rate", int'(rate), 0);
    check("reset_valid", int'(rate_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick(2);

    // Constant spikes, len 10: three windows of 10.
    spike_in = 1'b1;
    for (int i = 0; i < 3; i++) note_window(8'd10, 1'b1);
    enable = 1'b1;
    tick(31);
    enable = 1'b0;
    tick(2);

    // Alternating spikes, len 10: two windows of 5.
    for (int i = 0; i < 2; i++) note_window(8'd5, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 21; i++) begin
      spike_in = i[0];
      tick(1);
    end
    enable = 1'b0;
    tick(2);

    // window_len 0 behaves as 1: a result of 1 every cycle.
    window_len = 10'd0; spike_in = 1'b1;
    for (int i = 0; i < 5; i++) note_window(8'd1, 1'b1);
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(2);

    // len 300 saturates at 255.
    window_len = 10'd300;
    note_window(8'd255, 1'b1);
    enable = 1'b1;
    tick(301);
    enable = 1'b0;
    tick(2);

    // Overrun: two len-4 windows (4 then 2) with ready low.
    window_len = 10'd4; rate_ready = 1'b0; ovr_base = ovr_seen;
    note_window(8'd4, 1'b0);
    note_window(8'd2, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      spike_in = (i <= 4) ? 1'b1 : i[0];
      tick(1);
    end
    enable = 1'b0;
    check("overrun_pulse", int'(overrun), 1);
    check("overrun_valid_held", int'(rate_valid), 1);
    tick(1);
    check("overrun_one_cycle", int'(overrun), 0);
    check("valid_held_no_ready", int'(rate_valid), 1);
    rate_ready = 1'b1;
    tick(1);
    check("valid_cleared", int'(rate_valid), 0);
    check("overrun_count", ovr_seen - ovr_base, 1);

    // Enable dropped after 5 cycles of a len-10 window, then re-raised.
    window_len = 10'd10; spike_in = 1'b1;
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(1);
    check("partial_no_result", int'(rate_valid), 0);
    note_window(8'd10, 1'b1);
    enable = 1'b1;
    tick(11);
    enable = 1'b0;
    tick(2);

    // Reset mid-window with a pending result.
    window_len = 10'd4; rate_ready = 1'b0;
    note_window(8'd4, 1'b0);
    enable = 1'b1;
    tick(5);
    check("pending_before_reset", int'(rate_valid), 1);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    m_rate = 8'd0;
    check("midreset_rate", int'(rate), 0);
    check("midreset_valid", int'(rate_valid), 0);
    check("midreset_overrun", int'(overrun), 0);
    enable = 1'b0; rate_ready = 1'b1;
    rst_n = 1'b1;
    tick(2);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
